ram_io_sequencer: RTL and testbench

//  Host-side loader/unloader for the pairing core's multi-lane data RAM.

---
 rtl/ram_io_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ram_io_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_io_sequencer.sv
// ram_io_sequencer
//   Host-side loader/unloader for a multi-lane row RAM. A write command
//   gathers LANES serial words per row and commits each row with a one-cycle
//   strobe; a read command fetches rows and streams their lanes back out.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   core_busy             blocks command acceptance only
//   cmd_*                 command handshake: write/read, first row, row count
//   s_valid/s_ready/s_data            write word stream (into the block)
//   m_valid/m_ready/m_data/m_last     read word stream (out of the block)
//   ram_we/ram_waddr/ram_wdata        row write port
//   ram_raddr/ram_rdata               row read port, RD_LATENCY cycles
//   busy                  high whenever a command is in progress
module ram_io_sequencer #(
  parameter int WORD_SIZE  = 64,
  parameter int LANES      = 24,
  parameter int ADDR_SIZE  = 8,
  parameter int LEN_SIZE   = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         core_busy,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_SIZE-1:0]         cmd_addr,
  input  logic [LEN_SIZE-1:0]          cmd_len,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WORD_SIZE-1:0]         s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WORD_SIZE-1:0]         m_data,
  output logic                         m_last,
  output logic                         ram_we,
  output logic [ADDR_SIZE-1:0]         ram_waddr,
  output logic [LANES*WORD_SIZE-1:0]   ram_wdata,
  output logic [ADDR_SIZE-1:0]         ram_raddr,
  input  logic [LANES*WORD_SIZE-1:0]   ram_rdata,
  output logic                         busy
);

  localparam int ROW_W  = LANES * WORD_SIZE;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [WAIT_W-1:0]   LAST_WAIT = WAIT_W'(RD_LATENCY - 1);
  localparam logic [LEN_SIZE-1:0] ONE_ROW   = LEN_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WGATHER, S_WCOMMIT, S_RADDR, S_RWAIT, S_RSEND
  } state_t;

  state_t                 state_q,     state_d;
  logic [LANE_W-1:0]      lane_cnt_q,  lane_cnt_d;
  logic [WAIT_W-1:0]      wait_cnt_q,  wait_cnt_d;
  logic [LEN_SIZE-1:0]    rows_q,      rows_d;
  logic [ADDR_SIZE-1:0]   cur_addr_q,  cur_addr_d;
  logic [ROW_W-1:0]       buf_q,       buf_d;
  logic [ROW_W-1:0]       ram_wdata_q, ram_wdata_d;
  logic [ADDR_SIZE-1:0]   ram_waddr_q, ram_waddr_d;
  logic [ADDR_SIZE-1:0]   ram_raddr_q, ram_raddr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lane_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      rows_q      <= '0;
      cur_addr_q  <= '0;
      buf_q       <= '0;
      ram_wdata_q <= '0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rows_q      <= rows_d;
      cur_addr_q  <= cur_addr_d;
      buf_q       <= buf_d;
      ram_wdata_q <= ram_wdata_d;
      ram_waddr_q <= ram_waddr_d;
      ram_raddr_q <= ram_raddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rows_d      = rows_q;
    cur_addr_d  = cur_addr_q;
    buf_d       = buf_q;
    ram_wdata_d = ram_wdata_q;
    ram_waddr_d = ram_waddr_q;
    ram_raddr_d = ram_raddr_q;
    cmd_ready   = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    ram_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rst_n term keeps cmd_ready low for the whole reset window.
        cmd_ready = rst_n & ~core_busy;
        if (cmd_valid && cmd_ready) begin
          cur_addr_d = cmd_addr;
          rows_d     = cmd_len;
          lane_cnt_d = '0;
          wait_cnt_d = '0;
          if (cmd_len != '0) begin
            if (cmd_write) begin
              state_d = S_WGATHER;
            end else begin
              ram_raddr_d = cmd_addr;
              state_d     = S_RADDR;
            end
          end
        end
      end

      S_WGATHER: begin
        s_ready = 1'b1;
        if (s_valid) begin
          buf_d[lane_cnt_q*WORD_SIZE +: WORD_SIZE] = s_data;
          if (lane_cnt_q == LAST_LANE) begin
            // Snapshot the completed row so the write port holds it
            // stable while the next row is being gathered.
            lane_cnt_d  = '0;
            ram_wdata_d = buf_d;
            ram_waddr_d = cur_addr_q;
            state_d     = S_WCOMMIT;
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
          end
        end
      end

      S_WCOMMIT: begin
        ram_we     = 1'b1;
        rows_d     = rows_q - ONE_ROW;
        cur_addr_d = cur_addr_q + ADDR_SIZE'(1);
        state_d    = (rows_q == ONE_ROW) ? S_IDLE : S_WGATHER;
      end

      S_RADDR: begin
        wait_cnt_d = '0;
        state_d    = S_RWAIT;
      end

      S_RWAIT: begin
        // RWAIT spans RD_LATENCY cycles in total, so its last cycle is the
        // one where the RAM presents data for ram_raddr.
        if (wait_cnt_q == LAST_WAIT) begin
          buf_d      = ram_rdata;
          wait_cnt_d = '0;
          lane_cnt_d = '0;
          state_d    = S_RSEND;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_RSEND: begin
        m_valid = 1'b1;
        m_last  = (lane_cnt_q == LAST_LANE) && (rows_q == ONE_ROW);
        if (m_ready) begin
          if (lane_cnt_q == LAST_LANE) begin
            lane_cnt_d = '0;
            rows_d     = rows_q - ONE_ROW;
            if (rows_q == ONE_ROW) begin
              state_d = S_IDLE;
            end else begin
              cur_addr_d  = cur_addr_q + ADDR_SIZE'(1);
              ram_raddr_d = cur_addr_d;
              state_d     = S_RADDR;
            end
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign m_data    = buf_q[lane_cnt_q*WORD_SIZE +: WORD_SIZE];
  assign ram_wdata = ram_wdata_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_raddr = ram_raddr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_io_sequencer.sv
// tb_ram_io_sequencer
//   Drives ram_io_sequencer with directed and randomized commands. A row
//   memory model (latency 2) stands in for the RAM; expected row commits and
//   expected read words are derived from a reference copy of memory contents.
`timescale 1ns/1ps
module tb_ram_io_sequencer;
  localparam int W  = 64;
  localparam int L  = 24;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int RW = W * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_busy = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [RW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [RW-1:0] ram_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  ram_io_sequencer dut (
    .clk(clk), .rst_n(rst_n), .core_busy(core_busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Row RAM with two cycles of read latency.
  logic [RW-1:0] mem [256];
  logic [RW-1:0] rd_pipe = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_pipe   <= mem[ram_raddr];
    ram_rdata <= rd_pipe;
  end

  // Reference model state and scoreboards.
  logic [RW-1:0] ref_mem [256];
  logic [AW-1:0] exp_waddr[$];
  logic [RW-1:0] exp_wdata[$];
  logic [W-1:0]  exp_rd[$];
  bit            exp_last[$];
  logic [W-1:0]  rx_log[$];
  logic [W-1:0]  wq[$];
  int            last_idx = -1;
  int            we_cnt = 0;
  int            checks = 0;
  int            errors = 0;
  int            mr_mode = 0;   // 0: m_ready=1, 1: random, 2: 1-0-1 pattern
  int            busy_mode = 0; // 0: core_busy=0, 1: core_busy=1, 2: random
  int            gap_pct = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_row(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      int bad = 0;
      for (int k = L - 1; k >= 0; k--) if (got[k*W +: W] !== exp[k*W +: W]) bad = k;
      errors++;
      $display("FAIL %s: lane %0d got %0h expected %0h at %0t",
               name, bad, got[bad*W +: W], exp[bad*W +: W], $time);
    end
  endtask

  // Stream/response drivers, applied 2ns after each rising edge.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      cnt++;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(1));
        default: m_ready = ((cnt % 3) != 1);
      endcase
      case (busy_mode)
        0:       core_busy = 1'b0;
        1:       core_busy = 1'b1;
        default: core_busy = ($urandom_range(3) == 0);
      endcase
    end
  end

  // Single compare process: row commits, read words, stall stability.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_we) begin
        we_cnt++;
        chk("write_expected", 64'(exp_waddr.size() != 0), 1);
        if (exp_waddr.size() != 0) begin
          chk("ram_waddr", ram_waddr, exp_waddr.pop_front());
          chk_row("ram_wdata", ram_wdata, exp_wdata.pop_front());
        end
      end
      if (prev_stall) begin
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("read_expected", 64'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          chk("m_data", m_data, exp_rd.pop_front());
          chk("m_last", m_last, exp_last.pop_front());
        end
        rx_log.push_back(m_data);
        if (m_last) last_idx = rx_log.size() - 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a command; junk on the write stream while idle must be ignored.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] n);
    int ok = 0;
    cmd_write = w; cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
    s_valid = 1'($urandom_range(1)); s_data = {$urandom(), $urandom()} | 64'h8000_0000_0000_0000;
    for (int i = 0; i < 300 && ok == 0; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      tick();
    end
    cmd_valid = 1'b0; s_valid = 1'b0;
    chk("cmd_handshake", ok, 1);
  endtask

  task automatic feed();
    int i = 0;
    int cyc = 0;
    while (i < wq.size() && cyc < 5000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? wq[i] : {$urandom(), $urandom()};
      @(negedge clk);
      if (s_valid && s_ready) i++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    chk("feed_complete", i, wq.size());
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    chk(name, busy, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] n,
                          input bit seq, input logic [W-1:0] base);
    logic [RW-1:0] row;
    logic [W-1:0]  word;
    logic [AW-1:0] ra;
    wq.delete();
    for (int r = 0; r < int'(n); r++) begin
      for (int k = 0; k < L; k++) begin
        word = seq ? base + W'(r * L + k) : {$urandom(), $urandom()};
        wq.push_back(word);
        row[k*W +: W] = word;
      end
      ra = a + AW'(r);
      exp_waddr.push_back(ra);
      exp_wdata.push_back(row);
      ref_mem[ra] = row;
    end
    issue(1'b1, a, n);
    feed();
    wait_idle("write_idle");
  endtask

  task automatic push_read(input logic [AW-1:0] a, input logic [LW-1:0] n);
    logic [AW-1:0] ra;
    for (int r = 0; r < int'(n); r++) begin
      ra = a + AW'(r);
      for (int k = 0; k < L; k++) begin
        exp_rd.push_back(ref_mem[ra][k*W +: W]);
        exp_last.push_back((r == int'(n) - 1) && (k == L - 1));
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] n);
    push_read(a, n);
    issue(1'b0, a, n);
    wait_idle("read_idle");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int we0;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // Reset state; a pending request must not see cmd_ready.
    cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_waddr", ram_waddr, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    chk("rst_m_data", m_data, 0);
    chk_row("rst_ram_wdata", ram_wdata, '0);
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 1: reset after 5 gathered words, then a fresh single-row write.
    gap_pct = 0;
    we0 = we_cnt;
    wq.delete();
    for (int k = 0; k < 5; k++) wq.push_back(64'hBAD0 + 64'(k));
    issue(1'b1, 8'h20, 8'd1);
    feed();
    #1 rst_n = 1'b0;
    #1;
    chk("t1_async_busy", busy, 0);
    chk("t1_async_cmd_ready", cmd_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_no_commit", we_cnt, we0);
    gap_pct = 20;
    do_write(8'h20, 8'd1, 1'b1, 64'd100);
    chk("t1_lane0", mem[8'h20][0 +: W], 64'd100);
    chk("t1_lane23", mem[8'h20][23*W +: W], 64'd123);
    mr_mode = 1;
    do_read(8'h20, 8'd1);

    // 2: two-row write of words 0..47 at 0x10.
    we0 = we_cnt;
    gap_pct = 0;
    do_write(8'h10, 8'd2, 1'b1, 64'd0);
    chk("t2_we_pulses", we_cnt - we0, 2);
    chk("t2_row10_lane5", mem[8'h10][5*W +: W], 64'd5);
    chk("t2_row11_lane0", mem[8'h11][0 +: W], 64'd24);
    chk("t2_row11_lane23", mem[8'h11][23*W +: W], 64'd47);

    // 3: read back with m_ready tied high; first word 4 cycles after handshake.
    mr_mode = 0;
    tick();
    rx_log.delete();
    last_idx = -1;
    push_read(8'h10, 8'd2);
    issue(1'b0, 8'h10, 8'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 50);
    chk("t3_first_valid_latency", n, 4);
    tick();
    wait_idle("t3_idle");
    chk("t3_word_count", rx_log.size(), 48);
    chk("t3_word0", rx_log[0], 64'd0);
    chk("t3_word47", rx_log[47], 64'd47);
    chk("t3_last_index", last_idx, 47);

    // 4: read with m_ready toggling.
    mr_mode = 2;
    rx_log.delete();
    do_read(8'h10, 8'd2);
    chk("t4_word_count", rx_log.size(), 48);
    chk("t4_word30", rx_log[30], 64'd30);

    // 5: address wrap and zero-length commands.
    gap_pct = 25;
    do_write(8'hFF, 8'd2, 1'b1, 64'd1000);
    chk("t5_row_ff_lane0", mem[8'hFF][0 +: W], 64'd1000);
    chk("t5_row_00_lane0", mem[8'h00][0 +: W], 64'd1024);
    mr_mode = 1;
    do_read(8'hFF, 8'd2);
    we0 = we_cnt;
    issue(1'b1, 8'h40, 8'd0);
    @(negedge clk);
    chk("t5_len0_cmd_ready", cmd_ready, 1);
    chk("t5_len0_busy", busy, 0);
    issue(1'b0, 8'h40, 8'd0);
    repeat (6) tick();
    chk("t5_len0_no_we", we_cnt, we0);

    // 6: core_busy blocks acceptance; release is accepted the same cycle.
    busy_mode = 1;
    tick();
    cmd_write = 1'b0; cmd_addr = 8'h11; cmd_len = 8'd1; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_blocked_ready", cmd_ready, 0);
      chk("t6_blocked_busy", busy, 0);
      tick();
    end
    busy_mode = 0;
    @(negedge clk);
    chk("t6_release_ready", cmd_ready, 1);
    push_read(8'h11, 8'd1);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t6_accepted_busy", busy, 1);
    tick();
    wait_idle("t6_idle");

    // Randomized mix; core_busy toggles freely while commands run.
    busy_mode = 2;
    mr_mode = 1;
    gap_pct = 30;
    for (int it = 0; it < 30; it++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] len;
      a = AW'($urandom_range(255));
      len = LW'($urandom_range(3));
      if ($urandom_range(1) == 1) do_write(a, len, 1'b0, '0);
      else begin
        do_read(a, len);
      end
    end
    busy_mode = 0;
    repeat (4) tick();

    chk("pending_writes", exp_waddr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
